fft_out_reorder: RTL

Output-side reorder buffer for the 1024-point CORDIC FFT. It accepts the FFT's bit-reversed butterfly pairs (`o_valid_out`, A/B real/imag, Q16.16) and re-emits one natural-order bin per cycle on a valid/ready stream. A ping-pong pair of banks lets one frame be written while the previous frame drains. It sits directly after `fft` and feeds downstream spectral consumers.

---
 rtl/fft_out_reorder_if.sv | 46 ++++
 rtl/fft_out_reorder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder_if.sv
// fft_out_reorder_if: stream bundle for the FFT output reorder buffer.
//   Input side : i_valid_in strobe with butterfly pair A/B (real/imag).
//   Output side: o_valid/i_ready natural-order bin stream with o_bin index,
//                sticky o_overflow, and o_last when FFT_REORDER_LAST_EN is defined.
//   slave  modport: the reorder buffer.  master modport: FFT source + consumer.
interface fft_out_reorder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BIN_W  = 10
);
  logic              i_valid_in;
  logic [DATA_W-1:0] i_data_a_real;
  logic [DATA_W-1:0] i_data_a_imag;
  logic [DATA_W-1:0] i_data_b_real;
  logic [DATA_W-1:0] i_data_b_imag;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data_real;
  logic [DATA_W-1:0] o_data_imag;
  logic [BIN_W-1:0]  o_bin;
  logic              o_overflow;
`ifdef FFT_REORDER_LAST_EN
  logic              o_last;
`endif

  modport slave (
    input  i_valid_in, i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag,
    input  i_ready,
    output o_valid, o_data_real, o_data_imag, o_bin,
`ifdef FFT_REORDER_LAST_EN
    output o_overflow, output o_last
`else
    output o_overflow
`endif
  );

  modport master (
    output i_valid_in, i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag,
    output i_ready,
    input  o_valid, o_data_real, o_data_imag, o_bin,
`ifdef FFT_REORDER_LAST_EN
    input  o_overflow, input o_last
`else
    input  o_overflow
`endif
  );
endinterface

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong reorder buffer turning the FFT's bit-reversed
// butterfly pairs into one natural-order bin per cycle on a valid/ready stream.
//   i_clk, i_reset (async, active-low), bus (fft_out_reorder_if.slave).
//   Optional macro FFT_REORDER_LAST_EN adds o_last (high with bin N-1).
module fft_out_reorder #(
  parameter int unsigned N_POINTS = 1024,
  parameter int unsigned DATA_W   = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  fft_out_reorder_if.slave   bus
);
  localparam int unsigned L    = $clog2(N_POINTS);
  localparam int unsigned HW   = L - 1;
  localparam int unsigned HALF = N_POINTS / 2;
  localparam int unsigned WW   = 2 * DATA_W;

  typedef enum logic {ST_IDLE, ST_READ} state_t;

  function automatic logic [HW-1:0] bitrev_h(input logic [HW-1:0] x);
    logic [HW-1:0] r;
    for (int i = 0; i < int'(HW); i++) r[i] = x[HW-1-i];
    return r;
  endfunction

  // Sub-banks indexed by {bank, address}
  logic [WW-1:0] mem_lo [N_POINTS];
  logic [WW-1:0] mem_hi [N_POINTS];
  logic [WW-1:0] rd_data_q;

  logic [HW-1:0] wk_q, wk_d;
  logic          wb_q, wb_d;
  logic [1:0]    full_q, full_d;
  logic          discard_q, discard_d;
  logic          ovf_q, ovf_d;
  state_t        state_q, state_d;
  logic          ib_q, ib_d;
  logic          rb_q, rb_d;
  logic [L-1:0]  rbin_q, rbin_d;
  logic          rd_vld_q, rd_vld_d;
  logic [L-1:0]  rd_bin_q, rd_bin_d;
  logic          o_valid_q, o_valid_d;
  logic [WW-1:0] o_data_q, o_data_d;
  logic [L-1:0]  o_bin_q, o_bin_d;
  logic          o_last_q, o_last_d;

  logic disc_c, wr_en_c, set_full_c, clr_full_c, issue_c, load2_c, s1_free_c;

  // Write side: frame counter, bank select and discard decision
  always_comb begin
    wk_d       = wk_q;
    wb_d       = wb_q;
    discard_d  = discard_q;
    ovf_d      = ovf_q;
    disc_c     = discard_q;
    wr_en_c    = 1'b0;
    set_full_c = 1'b0;
    if (bus.i_valid_in) begin
      // Discard decision is taken once per frame and latched for its remainder
      if (wk_q == '0) disc_c = full_q[wb_q];
      discard_d = disc_c;
      wr_en_c   = !disc_c;
      if (disc_c) ovf_d = 1'b1;
      wk_d = wk_q + HW'(1);
      if (wk_q == HW'(HALF - 1) && !disc_c) begin
        set_full_c = 1'b1;
        wb_d       = !wb_q;
      end
    end
  end

  // Read side: issue into the registered-read stage, then into the output stage
  always_comb begin
    state_d    = state_q;
    ib_d       = ib_q;
    rb_d       = rb_q;
    rbin_d     = rbin_q;
    rd_vld_d   = rd_vld_q;
    rd_bin_d   = rd_bin_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_bin_d    = o_bin_q;
    o_last_d   = o_last_q;
    issue_c    = 1'b0;
    clr_full_c = 1'b0;

    load2_c   = rd_vld_q && (!o_valid_q || bus.i_ready);
    s1_free_c = !rd_vld_q || load2_c;

    case (state_q)
      ST_IDLE: begin
        if (full_q[ib_q]) begin
          state_d = ST_READ;
          issue_c = s1_free_c;
        end
      end
      ST_READ: issue_c = s1_free_c;
      default: state_d = ST_IDLE;
    endcase

    if (issue_c) begin
      rbin_d   = rbin_q + L'(1);
      rd_bin_d = rbin_q;
      // Issue side runs ahead of the drain, so it keeps its own bank pointer
      if (rbin_q == L'(N_POINTS - 1)) begin
        ib_d    = !ib_q;
        state_d = full_q[~ib_q] ? ST_READ : ST_IDLE;
      end
    end

    if (issue_c)      rd_vld_d = 1'b1;
    else if (load2_c) rd_vld_d = 1'b0;

    if (load2_c) begin
      o_valid_d = 1'b1;
      o_data_d  = rd_data_q;
      o_bin_d   = rd_bin_q;
      o_last_d  = (rd_bin_q == L'(N_POINTS - 1));
    end else if (o_valid_q && bus.i_ready) begin
      o_valid_d = 1'b0;
    end

    // Bank is released only when its last bin actually leaves
    if (o_valid_q && bus.i_ready && o_bin_q == L'(N_POINTS - 1)) begin
      clr_full_c = 1'b1;
      rb_d       = !rb_q;
    end
  end

  always_comb begin
    full_d = full_q;
    if (set_full_c) full_d[wb_q] = 1'b1;
    if (clr_full_c) full_d[rb_q] = 1'b0;
  end

  // Bank storage and registered read port
  always_ff @(posedge i_clk) begin
    if (wr_en_c) begin
      mem_lo[{wb_q, bitrev_h(wk_q)}] <= {bus.i_data_a_real, bus.i_data_a_imag};
      mem_hi[{wb_q, bitrev_h(wk_q)}] <= {bus.i_data_b_real, bus.i_data_b_imag};
    end
    if (issue_c) begin
      rd_data_q <= rbin_q[L-1] ? mem_hi[{ib_q, rbin_q[HW-1:0]}]
                               : mem_lo[{ib_q, rbin_q[HW-1:0]}];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wk_q      <= '0;
      wb_q      <= 1'b0;
      full_q    <= '0;
      discard_q <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      ib_q      <= 1'b0;
      rb_q      <= 1'b0;
      rbin_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_bin_q  <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_bin_q   <= '0;
      o_last_q  <= 1'b0;
    end else begin
      wk_q      <= wk_d;
      wb_q      <= wb_d;
      full_q    <= full_d;
      discard_q <= discard_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      ib_q      <= ib_d;
      rb_q      <= rb_d;
      rbin_q    <= rbin_d;
      rd_vld_q  <= rd_vld_d;
      rd_bin_q  <= rd_bin_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_bin_q   <= o_bin_d;
      o_last_q  <= o_last_d;
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_data_real = o_data_q[WW-1:DATA_W];
  assign bus.o_data_imag = o_data_q[DATA_W-1:0];
  assign bus.o_bin       = o_bin_q;
  assign bus.o_overflow  = ovf_q;
`ifdef FFT_REORDER_LAST_EN
  assign bus.o_last      = o_last_q;
`else
  logic unused_last;
  assign unused_last = o_last_q;
`endif
endmodule
